// File: rtl/bcd_counter_ctrl.sv
// bcd_counter_ctrl: run-control FSM, prescaler and cascaded BCD count register; `BCD_CTRL_SATURATE_EN selects hold-at-all-9s
module bcd_counter_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 10,
  parameter int PRESCALE_W = 4
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [1:0]              state,
  output logic                    running,
  output logic                    tc,
  output logic                    load_err
);
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;
  localparam int W = 4*NUM_DIGITS;
  logic [PRESCALE_W-1:0] pre;
  logic [W-1:0] inc, lv, wrap;
  logic all9, bad, tick, done_hit;
  logic [1:0] nxt;
  assign running = state == RUN;
  assign tick = running && pre == PRESCALE_W'(PRESCALE - 1);
  // carry ripples through every digit in one evaluation
  always_comb begin : incr
    logic c;
    c = 1'b1;
    all9 = 1'b1;
    inc = count;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      inc[4*i +: 4] = c ? (count[4*i +: 4] == 4'd9 ? 4'd0 : count[4*i +: 4] + 4'd1) : count[4*i +: 4];
      c = c && count[4*i +: 4] == 4'd9;
      all9 = all9 && count[4*i +: 4] == 4'd9;
    end
  end
  always_comb begin
    bad = 1'b0;
    lv = load_val;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lv[4*i +: 4] = load_val[4*i +: 4] > 4'd9 ? 4'd0 : load_val[4*i +: 4];
      bad = bad || load_val[4*i +: 4] > 4'd9;
    end
  end
`ifdef BCD_CTRL_SATURATE_EN
  assign wrap = count;
  assign done_hit = tick && all9;
`else
  assign wrap = '0;
  assign done_hit = 1'b0;
`endif
  always_comb
    nxt = (state == RUN)   ? (done_hit ? DONE : stop ? PAUSE : RUN) :
          (state == IDLE)  ? (start ? RUN : IDLE) :
          (state == PAUSE) ? (start && !stop ? RUN : PAUSE) : DONE;
  always_ff @(posedge CLK) begin
    if (reset) begin
      count <= '0;
      pre <= '0;
      state <= IDLE;
      tc <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tc <= 1'b0;
      load_err <= 1'b0;
      if (clear) begin
        count <= '0;
        pre <= '0;
        state <= IDLE;
      end else if (load && (state == IDLE || state == PAUSE)) begin
        count <= lv;
        pre <= '0;
        load_err <= bad;
      end else begin
        if (tick) begin
          count <= all9 ? wrap : inc;
          tc <= all9;
        end
        if (running) pre <= tick ? '0 : pre + 1'b1;
        state <= nxt;
      end
    end
  end
endmodule
